x_delay_fifo: RTL and testbench

Timed byte buffer placed between the UART receiver and the UART transmitter in the delay-line top level. It captures each received byte along with its arrival time. Each byte is released to the transmitter no earlier than `p_delay` clock cycles after arrival, in arrival order, under the transmitter's valid/accept handshake. It absorbs transmitter backpressure up to `p_depth` bytes and flags any loss.

---
 rtl/x_delay_pkg.sv | 14 +
 rtl/x_delay_ram.sv | 37 +++
 rtl/x_delay_fifo.sv | 125 ++++++++++++
 tb/tb_x_delay_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_delay_pkg.sv
// Shared types and sizing helper for the timed byte delay buffer.
// The timestamp width is derived from the worst-case age an entry can reach.
package x_delay_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t BYTE_ZERO = 8'h00;

  // An entry is compared at most p_delay + p_depth cycles after arrival; one extra bit keeps the age unambiguous.
  function automatic int ts_width(input int delay, input int depth);
    return $clog2(delay + depth) + 1;
  endfunction

endpackage

// File: rtl/x_delay_ram.sv
// Entry storage for the delay buffer: one write port and two combinational read
// ports (head byte, ripeness-frontier timestamp). Contents are never reset.
module x_delay_ram
  import x_delay_pkg::*;
#(
  parameter int p_depth = 16,
  parameter int p_ts_w  = 24
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(p_depth)-1:0] waddr_i,
  input  byte_t                      wdata_i,
  input  logic [p_ts_w-1:0]          wts_i,
  input  logic [$clog2(p_depth)-1:0] head_addr_i,
  output byte_t                      head_data_o,
  input  logic [$clog2(p_depth)-1:0] front_addr_i,
  output logic [p_ts_w-1:0]          front_ts_o
);

  typedef struct packed {
    byte_t               data;
    logic [p_ts_w-1:0]   ts;
  } entry_t;

  entry_t mem_q [p_depth];

  // Entry write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= '{data: wdata_i, ts: wts_i};
    end
  end

  assign head_data_o = mem_q[head_addr_i].data;
  assign front_ts_o  = mem_q[front_addr_i].ts;

endmodule

// File: rtl/x_delay_fifo.sv
// Timed byte buffer: each byte is released in arrival order no earlier than
// p_delay cycles after it was strobed in, under a valid/accept handshake.
module x_delay_fifo
  import x_delay_pkg::*;
#(
  parameter int p_depth = 16,
  parameter int p_delay = 5000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  byte_t                    i_data,
  output logic                     o_valid,
  output byte_t                    o_data,
  input  logic                     i_accept,
  output logic                     o_overflow,
  output logic [$clog2(p_depth):0] o_level
);

  localparam int TS_W = ts_width(p_delay, p_depth);
  localparam int AW   = $clog2(p_depth);
  localparam int PW   = AW + 1;

  localparam logic [TS_W-1:0] DELAY_TS = TS_W'(p_delay);
  localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);
  localparam logic [PW-1:0]   DEPTH_P  = PW'(p_depth);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  logic [TS_W-1:0] now_q, now_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic            ovf_q, ovf_d;

  logic [PW-1:0]   level_s;
  logic            full_s;
  logic            wr_en_s;
  logic            ripe_s;
  logic            offer_s;
  logic            pop_s;
  logic [TS_W-1:0] age_s;
  logic [TS_W-1:0] front_ts_s;
  byte_t           head_data_s;

  x_delay_ram #(
    .p_depth (p_depth),
    .p_ts_w  (TS_W)
  ) u_ram (
    .clk_i        (i_clk),
    .we_i         (wr_en_s),
    .waddr_i      (wr_q[AW-1:0]),
    .wdata_i      (i_data),
    .wts_i        (now_q),
    .head_addr_i  (rd_q[AW-1:0]),
    .head_data_o  (head_data_s),
    .front_addr_i (rp_q[AW-1:0]),
    .front_ts_o   (front_ts_s)
  );

  // Pointer, clock-count and overflow next-state; fullness is judged before any same-cycle pop
  always_comb begin
    level_s = wr_q - rd_q;
    full_s  = (level_s == DEPTH_P);
    wr_en_s = i_valid & ~full_s;
    age_s   = now_q - front_ts_s;
    ripe_s  = (rp_q != wr_q) && (age_s >= DELAY_TS);
    offer_s = (rd_q != rp_q);
    pop_s   = offer_s & i_accept;
    now_d   = now_q + TS_ONE;

    if (wr_en_s) begin
      wr_d = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end

    if (ripe_s) begin
      rp_d = rp_q + PTR_ONE;
    end else begin
      rp_d = rp_q;
    end

    if (pop_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end

    if (i_valid && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      now_q <= '0;
      wr_q  <= '0;
      rp_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      now_q <= now_d;
      wr_q  <= wr_d;
      rp_q  <= rp_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  // Output view of the pointer state; data is forced to zero when nothing is offered
  always_comb begin
    o_valid    = offer_s;
    o_overflow = ovf_q;
    o_level    = level_s;
    if (offer_s) begin
      o_data = head_data_s;
    end else begin
      o_data = BYTE_ZERO;
    end
  end

endmodule

// File: tb/tb_x_delay_fifo.sv
// Randomized and directed bench for x_delay_fifo (p_depth=4, p_delay=8) against
// a cycle-counting queue model of the release rules.
module tb_x_delay_fifo;
  import x_delay_pkg::*;

  localparam int P_DEPTH = 4;
  localparam int P_DELAY = 8;
  // TS_W = clog2(8+4)+1 = 5, so 3 * 2^5 cycles of stall
  localparam int STALL   = 96;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  byte_t       i_data = 8'h00;
  logic        i_accept = 1'b0;
  logic        o_valid;
  byte_t       o_data;
  logic        o_overflow;
  logic [2:0]  o_level;

  always #5 i_clk = ~i_clk;

  x_delay_fifo #(
    .p_depth (P_DEPTH),
    .p_delay (P_DELAY)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_accept   (i_accept),
    .o_overflow (o_overflow),
    .o_level    (o_level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued bytes with absolute arrival cycle, count of ripe head entries
  byte_t m_data[$];
  int    m_arr[$];
  int    m_ripe;
  bit    m_ovf;
  int    m_cyc;

  byte_t got_data[$];
  int    got_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_data.delete();
    m_arr.delete();
    m_ripe = 0;
    m_ovf  = 1'b0;
    m_cyc  = 0;
  endtask

  task automatic model_step(input logic v, input byte_t d, input logic a);
    bit full, ripen, pop;
    full  = (m_data.size() == P_DEPTH);
    pop   = (m_ripe > 0) && a;
    ripen = 1'b0;
    if (m_ripe < m_data.size()) begin
      ripen = ((m_cyc - m_arr[m_ripe]) >= P_DELAY);
    end
    if (ripen) m_ripe++;
    if (pop) begin
      void'(m_data.pop_front());
      void'(m_arr.pop_front());
      m_ripe--;
    end
    if (v) begin
      if (full) begin
        m_ovf = 1'b1;
      end else begin
        m_data.push_back(d);
        m_arr.push_back(m_cyc);
      end
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    check_val("o_valid", o_valid, (m_ripe > 0));
    check_val("o_data", o_data, (m_ripe > 0) ? m_data[0] : 8'h00);
    check_val("o_level", o_level, m_data.size());
    check_val("o_overflow", o_overflow, m_ovf);
  endtask

  // One clock cycle: drive at negedge, compare, let the edge happen, advance the model
  task automatic tick(input logic v, input byte_t d, input logic a);
    i_valid  = v;
    i_data   = d;
    i_accept = a;
    check_outputs();
    if (o_valid && a) begin
      got_data.push_back(o_data);
      got_cyc.push_back(m_cyc);
    end
    @(posedge i_clk);
    model_step(v, d, a);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n, input logic a);
    repeat (n) tick(1'b0, 8'h00, a);
  endtask

  task automatic do_reset();
    i_rst    = 1'b0;
    i_valid  = 1'b0;
    i_accept = 1'b0;
    #1;
    check_val("rst_valid", o_valid, 1'b0);
    check_val("rst_data", o_data, 8'h00);
    check_val("rst_level", o_level, 3'd0);
    check_val("rst_overflow", o_overflow, 1'b0);
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    got_data.delete();
    got_cyc.delete();
  endtask

  initial begin
    int s;
    byte_t exp_b;

    // Single byte
    do_reset();
    idle(10, 1'b1);
    s = m_cyc;
    tick(1'b1, 8'hA5, 1'b1);
    idle(15, 1'b1);
    check_val("single_count", got_data.size(), 1);
    if (got_data.size() >= 1) begin
      check_val("single_data", got_data[0], 8'hA5);
      check_val("single_latency", got_cyc[0] - s, P_DELAY + 1);
    end
    check_val("single_level", o_level, 3'd0);

    // Burst order
    got_data.delete();
    got_cyc.delete();
    s = m_cyc;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(i + 1), 1'b1);
    idle(15, 1'b1);
    check_val("burst_count", got_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_data.size()) begin
        check_val("burst_data", got_data[i], i + 1);
        check_val("burst_cycle", got_cyc[i] - s, P_DELAY + 1 + i);
      end
    end

    // Backpressure and overflow
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0);
    check_val("bp_level", o_level, 3'd4);
    check_val("bp_overflow", o_overflow, 1'b1);
    idle(12, 1'b0);
    idle(20, 1'b1);
    check_val("bp_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h10 + 8'(i);
      if (i < got_data.size()) check_val("bp_data", got_data[i], exp_b);
    end

    // Full buffer, strobe coinciding with a pop
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'h20 + 8'(i), 1'b0);
    idle(10, 1'b0);
    check_val("fp_head_ripe", o_valid, 1'b1);
    tick(1'b1, 8'hEE, 1'b1);
    check_val("fp_level", o_level, 3'd3);
    check_val("fp_overflow", o_overflow, 1'b1);
    idle(20, 1'b1);
    check_val("fp_count", got_data.size(), 4);

    // Long stall across several timestamp wraps
    do_reset();
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b1, 8'hC3, 1'b0);
    idle(STALL, 1'b0);
    s = m_cyc;
    idle(5, 1'b1);
    check_val("stall_count", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check_val("stall_data0", got_data[0], 8'h5A);
      check_val("stall_data1", got_data[1], 8'hC3);
      check_val("stall_cycle", got_cyc[0] - s, 0);
    end

    // Reset with bytes in flight and overflow set
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h30 + 8'(i), 1'b0);
    idle(5, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    check_val("mid_level", o_level, 3'd3);
    check_val("mid_overflow", o_overflow, 1'b1);
    do_reset();
    idle(3, 1'b1);
    s = m_cyc;
    tick(1'b1, 8'h77, 1'b1);
    idle(12, 1'b1);
    check_val("post_rst_count", got_data.size(), 1);
    if (got_data.size() == 1) begin
      check_val("post_rst_data", got_data[0], 8'h77);
      check_val("post_rst_latency", got_cyc[0] - s, P_DELAY + 1);
    end

    // Randomized traffic with varying acceptance rate
    do_reset();
    for (int blk = 0; blk < 30; blk++) begin
      int pa;
      int pv;
      pa = $urandom_range(0, 100);
      pv = $urandom_range(10, 70);
      repeat (100) begin
        tick(($urandom_range(0, 99) < pv), 8'($urandom), ($urandom_range(0, 99) < pa));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
